// File: rtl/m68k_bus_arbiter.sv
// rtl/m68k_bus_arbiter.sv - 68000 bus arbiter: BR/BG/BGACK handshake, hold limit, turnaround gap.
// Optional M68K_BUS_ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of fixed priority.
module m68k_bus_arbiter #(
    parameter int NREQ     = 2,
    parameter int MAX_HOLD = 0,
    parameter int TURN     = 2
) (
    input  logic            MCLK,
    input  logic            reset,
    input  logic            clk_en,
    input  logic [NREQ-1:0] req,
    input  logic            cpu_bg,
    input  logic            cpu_as,
    output logic            cpu_br,
    output logic            cpu_bgack,
    output logic [NREQ-1:0] grant,
    output logic [2:0]      owner,
    output logic            busy,
    output logic            preempt
);
    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [3:0]        TURN_LAST = 4'(TURN - 1);

    typedef enum logic [1:0] {IDLE, REQUEST, OWNED, RELEASE} state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_owner, w_owner_nxt;
    logic              r_br, w_br_nxt;
    logic              r_bgack, w_bgack_nxt;
    logic [NREQ-1:0]   r_grant, w_grant_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_preempt, w_preempt_nxt;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt;
    logic [3:0]        r_turn, w_turn_nxt;
    logic [2:0]        w_win;
    logic              w_owner_req;
    logic [NREQ-1:0]   w_owner_onehot;
    logic              w_hold_exp;

`ifdef M68K_BUS_ARB_ROUND_ROBIN_EN
    logic [2:0] r_last, w_last_nxt;
    int         w_start;
    logic       w_found;

    // Search begins just past the previous owner so every requester gets a turn.
    always_comb begin
        w_win   = 3'd0;
        w_found = 1'b0;
        w_start = (int'(r_last) + 1) % NREQ;
        for (int k = 0; k < NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!w_found && ((w_start + k) % NREQ) == j && req[j]) begin
                    w_win   = 3'(j);
                    w_found = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        w_win = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) w_win = 3'(i);
        end
    end
`endif

    always_comb begin
        w_owner_req    = 1'b0;
        w_owner_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_owner_req       = req[i];
                w_owner_onehot[i] = 1'b1;
            end
        end
    end

    assign w_hold_exp = (MAX_HOLD != 0) && (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_br_nxt      = r_br;
        w_bgack_nxt   = r_bgack;
        w_grant_nxt   = r_grant;
        w_hold_nxt    = r_hold;
        w_turn_nxt    = r_turn;
        w_preempt_nxt = 1'b0;
`ifdef M68K_BUS_ARB_ROUND_ROBIN_EN
        w_last_nxt    = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_owner_nxt = w_win;
                    w_br_nxt    = 1'b1;
                    w_state_nxt = REQUEST;
                end
            end
            REQUEST: begin
                if (!w_owner_req) begin
                    w_br_nxt    = 1'b0;
                    w_turn_nxt  = 4'd0;
                    w_state_nxt = RELEASE;
                end else if (cpu_bg && !cpu_as) begin
                    w_grant_nxt = w_owner_onehot;
                    w_bgack_nxt = 1'b1;
                    w_hold_nxt  = '0;
                    w_state_nxt = OWNED;
`ifdef M68K_BUS_ARB_ROUND_ROBIN_EN
                    w_last_nxt  = r_owner;
`endif
                end
            end
            OWNED: begin
                w_br_nxt = 1'b0;
                if (r_hold != {HOLD_W{1'b1}}) w_hold_nxt = r_hold + 1'b1;
                // A forced release is only a preemption while the owner still wants the bus.
                if (!w_owner_req || w_hold_exp) begin
                    w_grant_nxt   = '0;
                    w_bgack_nxt   = 1'b0;
                    w_turn_nxt    = 4'd0;
                    w_preempt_nxt = w_owner_req;
                    w_state_nxt   = RELEASE;
                end
            end
            RELEASE: begin
                if (r_turn >= TURN_LAST) w_state_nxt = IDLE;
                else                     w_turn_nxt  = r_turn + 4'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge MCLK or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_owner   <= 3'd0;
            r_br      <= 1'b0;
            r_bgack   <= 1'b0;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b0;
            r_hold    <= '0;
            r_turn    <= 4'd0;
`ifdef M68K_BUS_ARB_ROUND_ROBIN_EN
            r_last    <= 3'(NREQ - 1);
`endif
        end else if (clk_en) begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_br      <= w_br_nxt;
            r_bgack   <= w_bgack_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= w_busy_nxt;
            r_preempt <= w_preempt_nxt;
            r_hold    <= w_hold_nxt;
            r_turn    <= w_turn_nxt;
`ifdef M68K_BUS_ARB_ROUND_ROBIN_EN
            r_last    <= w_last_nxt;
`endif
        end
    end

    assign cpu_br    = r_br;
    assign cpu_bgack = r_bgack;
    assign grant     = r_grant;
    assign owner     = r_owner;
    assign busy      = r_busy;
    assign preempt   = r_preempt;
endmodule
